// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Arbitrates the single register-bank write port between returning load
//   data and a one-entry ALU result holding register, and tracks which
//   registers still await a load writeback (scoreboard for hazards).
//
// Ports
//   clk, reset                : clock, asynchronous active-high reset
//   alu_valid/reg/data/ready  : ALU result channel (valid/ready)
//   load_issue/_reg/_ready    : load issue channel, marks destination pending
//   load_valid/reg/data/ready : load return channel (valid/ready)
//   rs0, rs1                  : source registers read this cycle
//   hazard                    : a source register awaits a load writeback
//   wb_en, wb_reg, wb_data    : register bank write port (registered)
//   protocol_err              : sticky error flag
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// when valid and ready are both 1 in the cycle before it. Ready never depends
// on the same channel's valid, and valid/payload are assumed held until the
// transfer completes.
module writeback_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [3:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        load_issue,
  input  logic [3:0]  load_issue_reg,
  output logic        load_issue_ready,
  input  logic        load_valid,
  input  logic [3:0]  load_reg,
  input  logic [31:0] load_data,
  output logic        load_ready,
  input  logic [3:0]  rs0,
  input  logic [3:0]  rs1,
  output logic        hazard,
  output logic        wb_en,
  output logic [3:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        protocol_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [15:0]   pending_q, pending_d;
  logic          hold_valid_q, hold_valid_d;
  logic [3:0]    hold_reg_q, hold_reg_d;
  logic [31:0]   hold_data_q, hold_data_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          wb_en_q, wb_en_d;
  logic [3:0]    wb_reg_q, wb_reg_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          wb_from_load_q, wb_from_load_d;
  logic          perr_q, perr_d;

  logic load_sel, hold_sel, alu_acc, issue_acc;

  always_comb begin
    // Load wins unless a held ALU result has already lost LIMIT times.
    load_sel         = load_valid && (starve_q < LIMIT);
    hold_sel         = !load_sel && hold_valid_q;
    load_ready       = !(hold_valid_q && (starve_q >= LIMIT));
    alu_ready        = !hold_valid_q || hold_sel;
    load_issue_ready = !pending_q[load_issue_reg] || (load_issue_reg == 4'd0);
    hazard           = pending_q[rs0] || pending_q[rs1];
    alu_acc          = alu_valid && alu_ready;
    issue_acc        = load_issue && load_issue_ready;
  end

  always_comb begin
    pending_d      = pending_q;
    hold_valid_d   = hold_valid_q;
    hold_reg_d     = hold_reg_q;
    hold_data_d    = hold_data_q;
    starve_d       = starve_q;
    wb_en_d        = 1'b0;
    wb_reg_d       = wb_reg_q;
    wb_data_d      = wb_data_q;
    wb_from_load_d = 1'b0;
    perr_d         = perr_q;

    // Clear first so that a same-edge issue to the same register wins.
    if (wb_en_q && wb_from_load_q) pending_d[wb_reg_q] = 1'b0;
    if (issue_acc && (load_issue_reg != 4'd0)) pending_d[load_issue_reg] = 1'b1;
    pending_d[0] = 1'b0;

    // Hold slot: a selected hold drains; an accepted ALU result refills it
    // in the same cycle (alu_ready allows this only when it drains).
    if (hold_sel) hold_valid_d = 1'b0;
    if (alu_acc) begin
      hold_valid_d = 1'b1;
      hold_reg_d   = alu_reg;
      hold_data_d  = alu_data;
    end

    if (hold_valid_q && load_sel) starve_d = starve_q + 1'b1;
    else                          starve_d = '0;

    if (load_sel) begin
      wb_reg_d       = load_reg;
      wb_data_d      = load_data;
      wb_en_d        = (load_reg != 4'd0);
      wb_from_load_d = 1'b1;
    end else if (hold_sel) begin
      wb_reg_d  = hold_reg_q;
      wb_data_d = hold_data_q;
      wb_en_d   = (hold_reg_q != 4'd0);
    end

    if (load_sel && (load_reg != 4'd0) && !pending_q[load_reg]) perr_d = 1'b1;
    if (alu_acc && pending_q[alu_reg]) perr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q      <= '0;
      hold_valid_q   <= 1'b0;
      hold_reg_q     <= '0;
      hold_data_q    <= '0;
      starve_q       <= '0;
      wb_en_q        <= 1'b0;
      wb_reg_q       <= '0;
      wb_data_q      <= '0;
      wb_from_load_q <= 1'b0;
      perr_q         <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      hold_valid_q   <= hold_valid_d;
      hold_reg_q     <= hold_reg_d;
      hold_data_q    <= hold_data_d;
      starve_q       <= starve_d;
      wb_en_q        <= wb_en_d;
      wb_reg_q       <= wb_reg_d;
      wb_data_q      <= wb_data_d;
      wb_from_load_q <= wb_from_load_d;
      perr_q         <= perr_d;
    end
  end

  assign wb_en        = wb_en_q;
  assign wb_reg       = wb_reg_q;
  assign wb_data      = wb_data_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [3:0]  alu_reg;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        load_issue;
  logic [3:0]  load_issue_reg;
  logic        load_issue_ready;
  logic        load_valid;
  logic [3:0]  load_reg;
  logic [31:0] load_data;
  logic        load_ready;
  logic [3:0]  rs0, rs1;
  logic        hazard;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        protocol_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  writeback_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .load_issue(load_issue), .load_issue_reg(load_issue_reg), .load_issue_ready(load_issue_ready),
    .load_valid(load_valid), .load_reg(load_reg), .load_data(load_data), .load_ready(load_ready),
    .rs0(rs0), .rs1(rs1), .hazard(hazard),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .protocol_err(protocol_err)
  );

  typedef struct {
    logic        av;  logic [3:0] ar;  logic [31:0] ad;
    logic        li;  logic [3:0] lir;
    logic        lv;  logic [3:0] lr;  logic [31:0] ld;
    logic [3:0]  rs0; logic [3:0] rs1;
    logic        e_ar; logic e_lr; logic e_ir; logic e_hz;
    logic        e_we; logic [3:0] e_wr; logic [31:0] e_wd; logic e_pe;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_reg = 0; alu_data = 0;
    load_issue = 0; load_issue_reg = 0;
    load_valid = 0; load_reg = 0; load_data = 0;
    rs0 = 0; rs1 = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_vec(input int i);
    string t;
    alu_valid = vecs[i].av;  alu_reg = vecs[i].ar;  alu_data = vecs[i].ad;
    load_issue = vecs[i].li; load_issue_reg = vecs[i].lir;
    load_valid = vecs[i].lv; load_reg = vecs[i].lr; load_data = vecs[i].ld;
    rs0 = vecs[i].rs0; rs1 = vecs[i].rs1;
    #1;
    t = $sformatf("v%0d", i);
    chk({t, " alu_ready"},        32'(alu_ready),        32'(vecs[i].e_ar));
    chk({t, " load_ready"},       32'(load_ready),       32'(vecs[i].e_lr));
    chk({t, " load_issue_ready"}, 32'(load_issue_ready), 32'(vecs[i].e_ir));
    chk({t, " hazard"},           32'(hazard),           32'(vecs[i].e_hz));
    chk({t, " wb_en"},            32'(wb_en),            32'(vecs[i].e_we));
    chk({t, " wb_reg"},           32'(wb_reg),           32'(vecs[i].e_wr));
    chk({t, " wb_data"},          wb_data,               vecs[i].e_wd);
    chk({t, " protocol_err"},     32'(protocol_err),     32'(vecs[i].e_pe));
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          av ar ad     li lir lv lr ld            rs0 rs1 | ar lr ir hz we wr wd            pe
    // load x5 returns three cycles after issue; hazard until cycle after wb
    vecs[0]  = '{0, 0, 0,     0, 0,  0, 0, 0,            0, 0,   1, 1, 1, 0, 0, 0, 0,            0};
    vecs[1]  = '{0, 0, 0,     1, 5,  0, 0, 0,            5, 0,   1, 1, 1, 0, 0, 0, 0,            0};
    vecs[2]  = '{0, 0, 0,     0, 0,  0, 0, 0,            5, 0,   1, 1, 1, 1, 0, 0, 0,            0};
    vecs[3]  = '{0, 0, 0,     0, 0,  0, 0, 0,            0, 5,   1, 1, 1, 1, 0, 0, 0,            0};
    vecs[4]  = '{0, 0, 0,     0, 0,  1, 5, 32'hDEADBEEF, 5, 0,   1, 1, 1, 1, 0, 0, 0,            0};
    vecs[5]  = '{0, 0, 0,     0, 0,  0, 0, 0,            5, 0,   1, 1, 1, 1, 1, 5, 32'hDEADBEEF, 0};
    vecs[6]  = '{0, 0, 0,     0, 0,  0, 0, 0,            5, 0,   1, 1, 1, 0, 0, 5, 32'hDEADBEEF, 0};
    // x7 issued twice: second issue stalls until x7 written back
    vecs[7]  = '{0, 0, 0,     1, 7,  0, 0, 0,            0, 0,   1, 1, 1, 0, 0, 5, 32'hDEADBEEF, 0};
    vecs[8]  = '{0, 0, 0,     1, 7,  0, 0, 0,            0, 0,   1, 1, 0, 0, 0, 5, 32'hDEADBEEF, 0};
    vecs[9]  = '{0, 0, 0,     1, 7,  1, 7, 32'h77,       0, 0,   1, 1, 0, 0, 0, 5, 32'hDEADBEEF, 0};
    vecs[10] = '{0, 0, 0,     1, 7,  0, 0, 0,            0, 0,   1, 1, 0, 0, 1, 7, 32'h77,       0};
    vecs[11] = '{0, 0, 0,     1, 7,  0, 0, 0,            0, 0,   1, 1, 1, 0, 0, 7, 32'h77,       0};
    vecs[12] = '{0, 0, 0,     0, 0,  1, 7, 32'h78,       0, 0,   1, 1, 1, 0, 0, 7, 32'h77,       0};
    vecs[13] = '{0, 0, 0,     0, 0,  0, 0, 0,            0, 0,   1, 1, 1, 0, 1, 7, 32'h78,       0};
    vecs[14] = '{0, 0, 0,     0, 0,  0, 0, 0,            0, 0,   1, 1, 1, 0, 0, 7, 32'h78,       0};
    // ALU write to x0: handshake completes, wb_en never rises
    vecs[15] = '{1, 0, 32'h55, 0, 0, 0, 0, 0,            0, 0,   1, 1, 1, 0, 0, 7, 32'h78,       0};
    vecs[16] = '{0, 0, 0,     0, 0,  0, 0, 0,            0, 0,   1, 1, 1, 0, 0, 7, 32'h78,       0};
    vecs[17] = '{0, 0, 0,     0, 0,  0, 0, 0,            0, 0,   1, 1, 1, 0, 0, 0, 32'h55,       0};
    // ALU x3 starved by six cycles of load_valid: forced after 4 losses
    vecs[18] = '{1, 3, 32'h11, 0, 0, 0, 0, 0,            0, 0,   1, 1, 1, 0, 0, 0, 32'h55,       0};
    vecs[19] = '{0, 0, 0,     0, 0,  1, 0, 32'hA1,       0, 0,   0, 1, 1, 0, 0, 0, 32'h55,       0};
    vecs[20] = '{0, 0, 0,     0, 0,  1, 0, 32'hA2,       0, 0,   0, 1, 1, 0, 0, 0, 32'hA1,       0};
    vecs[21] = '{0, 0, 0,     0, 0,  1, 0, 32'hA3,       0, 0,   0, 1, 1, 0, 0, 0, 32'hA2,       0};
    vecs[22] = '{0, 0, 0,     0, 0,  1, 0, 32'hA4,       0, 0,   0, 1, 1, 0, 0, 0, 32'hA3,       0};
    vecs[23] = '{0, 0, 0,     0, 0,  1, 0, 32'hA5,       0, 0,   1, 0, 1, 0, 0, 0, 32'hA4,       0};
    vecs[24] = '{0, 0, 0,     0, 0,  1, 0, 32'hA5,       0, 0,   1, 1, 1, 0, 1, 3, 32'h11,       0};
    vecs[25] = '{0, 0, 0,     0, 0,  0, 0, 0,            0, 0,   1, 1, 1, 0, 0, 0, 32'hA5,       0};

    // clock/reset
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 26; i++) apply_vec(i);

    // Unexpected load return to x9: sticky protocol error, still written
    load_valid = 1; load_reg = 9; load_data = 32'h99;
    #1 chk("perr before bad load", 32'(protocol_err), 32'd0);
    next_cycle();
    idle_inputs();
    #1;
    chk("perr after bad load", 32'(protocol_err), 32'd1);
    chk("bad load wb_en", 32'(wb_en), 32'd1);
    chk("bad load wb_reg", 32'(wb_reg), 32'd9);
    repeat (3) next_cycle();
    chk("perr sticky", 32'(protocol_err), 32'd1);
    #2 reset = 1'b1;
    #1 chk("perr cleared by async reset", 32'(protocol_err), 32'd0);
    next_cycle();
    reset = 1'b0;

    // Reset mid-operation with a held ALU result and x4 pending
    load_issue = 1; load_issue_reg = 4;
    next_cycle();
    idle_inputs();
    alu_valid = 1; alu_reg = 6; alu_data = 32'h66;
    load_valid = 1; load_reg = 4; load_data = 32'h44;
    next_cycle();
    idle_inputs();
    load_valid = 1; load_reg = 0; load_data = 32'h0;
    rs0 = 4;
    #1;
    chk("pre-reset hazard", 32'(hazard), 32'd1);
    chk("pre-reset wb_en", 32'(wb_en), 32'd1);
    chk("pre-reset hold blocks alu", 32'(alu_ready), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("reset wb_en", 32'(wb_en), 32'd0);
    chk("reset hazard", 32'(hazard), 32'd0);
    chk("reset wb_reg", 32'(wb_reg), 32'd0);
    chk("reset wb_data", wb_data, 32'd0);
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    rs0 = 4;
    #1;
    chk("post-reset alu_ready", 32'(alu_ready), 32'd1);
    chk("post-reset load_ready", 32'(load_ready), 32'd1);
    load_issue_reg = 4;
    #1;
    chk("post-reset load_issue_ready", 32'(load_issue_ready), 32'd1);
    chk("post-reset hazard", 32'(hazard), 32'd0);
    load_issue_reg = 0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk($sformatf("no stale write %0d", i), 32'(wb_en), 32'd0);
    end

    // ALU result targeting a register still awaiting its load
    load_issue = 1; load_issue_reg = 8;
    next_cycle();
    idle_inputs();
    alu_valid = 1; alu_reg = 8; alu_data = 32'h88;
    #1 chk("alu to pending alu_ready", 32'(alu_ready), 32'd1);
    next_cycle();
    idle_inputs();
    #1 chk("alu to pending perr", 32'(protocol_err), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
